key_cmd_scheduler: RTL
======================

KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

Interface
REQ-001 Parameter HOLDOFF, default 16: idle cycles enforced after each accepted command, legal range 1..255.
REQ-002 Parameter CMD0, default 8'h30: command byte for requester 0.
REQ-003 Parameter CMD1, default 8'h31: command byte for requester 1.
REQ-004 Parameter CMD2, default 8'h32: command byte for requester 2.
REQ-005 Parameter CMD3, default 8'h33: command byte for requester 3.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 req_pulse  input  4  one-cycle pulses from per-key debounce/one-shot stages; bit i = requester i.
REQ-009 ovf_clr  input  1  clears ovf when high for one cycle.
REQ-010 tx_ready  input  1  downstream UART transmitter accepts byte when high with tx_valid.
REQ-011 tx_valid  output  1  command byte valid.
REQ-012 tx_data  output  8  command byte of granted requester.
REQ-013 grant  output  4  one-hot granted requester, zero when not in SEND.
REQ-014 pending  output  4  latched, not-yet-granted requests.
REQ-015 busy  output  1  high in SEND or HOLD.
REQ-016 ovf  output  1  sticky: a pulse arrived for a bit already pending.

Function
REQ-017 Every requirement is registered; all outputs come from flops, none combinational from inputs.
REQ-018 pending[i] sets on the cycle after req_pulse[i]=1; it clears on the cycle after requester i is granted (SEND entry).
REQ-019 Set and clear of the same pending bit in the same cycle: set wins, bit stays 1.
REQ-020 req_pulse[i]=1 while pending[i]=1 and not cleared that cycle: request merged, ovf set next cycle.
REQ-021 ovf_clr and a new overflow in the same cycle: set wins.
REQ-022 FSM states: IDLE, SEND, HOLD.
REQ-023 IDLE: if pending!=0, go to SEND next cycle with grant, tx_data, tx_valid=1 loaded; else stay.
REQ-024 Arbitration is round-robin over pending: search starts at index rr_ptr, wraps 3->0; first set bit wins.
REQ-025 rr_ptr resets to 0; on grant of i, rr_ptr becomes (i+1) mod 4.
REQ-026 SEND: tx_valid, tx_data, grant held stable until tx_valid&tx_ready; on that cycle go to HOLD, drop tx_valid and grant next cycle.
REQ-027 Byte accepted on the first cycle with tx_ready=1 while in SEND; no byte issued twice.
REQ-028 HOLD: counter loads HOLDOFF-1 on entry, decrements each cycle, returns to IDLE the cycle after it reaches 0; HOLD lasts exactly HOLDOFF cycles.
REQ-029 Pulses arriving during SEND or HOLD are latched into pending, never lost except by REQ-020 merge.
REQ-030 Minimum spacing between consecutive accepted bytes: HOLDOFF+2 cycles (HOLD + IDLE + SEND).
REQ-031 tx_data = CMDi for granted i; 8'h00 when tx_valid=0.

Reset
REQ-032 rst_n=0 at a rising edge forces state IDLE, pending=0, rr_ptr=0, counter=0, ovf=0, tx_valid=0, tx_data=0, grant=0, busy=0, next cycle.
REQ-033 Reset asserted mid-SEND or mid-HOLD aborts the command; pulses in reset cycles are ignored.
REQ-034 Reset overrides every other input in the same cycle.

Verification
REQ-035 Single: req_pulse=4'b0100, tx_ready=1 -> pending=4'b0100 next cycle, then tx_valid=1, tx_data=8'h32, grant=4'b0100 one cycle, busy for 17 cycles total.
REQ-036 Fairness: req_pulse=4'b1111 once, tx_ready=1, HOLDOFF=16 -> bytes 30,31,32,33 in order, 18 cycles apart.
REQ-037 Backpressure: req 0, tx_ready=0 for 10 cycles -> tx_valid, tx_data=8'h30 stable 10 cycles; accepted once on tx_ready=1.
REQ-038 Rotation: grant 1, then pulses 4'b0011 during HOLD -> next grant is 0 only after 1? no: rr_ptr=2 -> wraps, grant 0 then 1.
REQ-039 Overflow: req_pulse[3] twice while pending[3]=1 -> ovf=1, one 8'h33 byte only; ovf_clr -> ovf=0.
REQ-040 Reset in HOLD with pending=4'b0010 -> all outputs 0, no byte issued after reset release until new pulse.

Source files
------------

// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler
//   Latches one-shot key requests, arbitrates them round-robin and hands the
//   winning requester's command byte to a UART transmitter, then enforces a
//   fixed idle hold-off before the next byte.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   req_pulse  [3:0] one-cycle request pulses, bit i = requester i
//   ovf_clr    clears the sticky overflow flag
//   tx_ready   transmitter accepts the byte when high with tx_valid
//   tx_valid   command byte valid
//   tx_data    [7:0] command byte of the granted requester, 0 when idle
//   grant      [3:0] one-hot granted requester, 0 outside SEND
//   pending    [3:0] latched requests not yet granted
//   busy       high in SEND or HOLD
//   ovf        sticky: a pulse arrived for an already pending requester

// One requester's pending bit. A new pulse beats a same-cycle grant clear,
// so a request arriving exactly as the old one is granted is kept.
module key_cmd_pend_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic clr,
  output logic pend,
  output logic merge
);
  always_ff @(posedge clk) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= req | (pend & ~clr);
  end

  // Pulse folded into a request that is still waiting.
  assign merge = req & pend & ~clr;
endmodule

module key_cmd_scheduler #(
  parameter int         HOLDOFF = 16,
  parameter logic [7:0] CMD0    = 8'h30,
  parameter logic [7:0] CMD1    = 8'h31,
  parameter logic [7:0] CMD2    = 8'h32,
  parameter logic [7:0] CMD3    = 8'h33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_pulse,
  input  logic       ovf_clr,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [3:0] grant,
  output logic [3:0] pending,
  output logic       busy,
  output logic       ovf
);
  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  logic [NUM_REQ-1:0][7:0] cmd_tab;
  assign cmd_tab = {CMD3, CMD2, CMD1, CMD0};

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [1:0]         rr_q, rr_d;
  logic               tx_valid_d;
  logic [7:0]         tx_data_d;
  logic [3:0]         grant_d;
  logic [NUM_REQ-1:0] clr, merge;
  logic               win_any;
  logic [1:0]         win_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    key_cmd_pend_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_pulse[i]),
      .clr   (clr[i]),
      .pend  (pending[i]),
      .merge (merge[i])
    );
  end

  // Round-robin pick: scan offsets high to low so the smallest offset from
  // rr_q is the last (and winning) assignment.
  always_comb begin
    logic [1:0] idx;
    win_any = 1'b0;
    win_idx = rr_q;
    idx     = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = rr_q + 2'(k);
      if (pending[idx]) begin
        win_any = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    grant_d    = grant;
    clr        = '0;
    case (state_q)
      IDLE: if (win_any) begin
        state_d    = SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = cmd_tab[win_idx];
        grant_d    = 4'b0001 << win_idx;
        clr        = 4'b0001 << win_idx;
        rr_d       = win_idx + 2'd1;
      end
      SEND: if (tx_ready) begin
        state_d    = HOLD;
        cnt_d      = 8'(HOLDOFF - 1);
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        grant_d    = '0;
      end
      HOLD: begin
        // Counter runs HOLDOFF-1 .. 0, one cycle each: HOLDOFF cycles total.
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_q     <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      grant    <= grant_d;
      busy     <= (state_d != IDLE);
      // New overflow beats a same-cycle clear.
      ovf      <= (|merge) | (ovf & ~ovf_clr);
    end
  end
endmodule
